// File: rtl/request_dispatcher_pkg.sv
// Shared constants for the request dispatcher: default widths, queue entry layout, clog2 helper.
// Entry layout in every way queue is {critical, payload}, critical in the MSB.
package request_dispatcher_pkg;

  localparam int DEF_NUM_REQUEST     = 3;
  localparam int DEF_REQUEST_WIDTH   = 64;
  localparam int DEF_QUEUE_DEPTH     = 4;
  localparam int HANDSHAKE_VALID_W   = 1;
  localparam int HANDSHAKE_ACK_W     = 1;

  typedef struct packed {
    logic                         critical;
    logic [DEF_REQUEST_WIDTH-1:0] payload;
  } entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dispatch_queue.sv
// Single-clock FIFO for one dispatcher way; push visible at head the cycle after the write edge.
// Push while full and pop while empty are dropped; no bypass, no pass-through when full.
module dispatch_queue
  import request_dispatcher_pkg::*;
#(
  parameter int WIDTH = DEF_REQUEST_WIDTH + 1,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_push_dat,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head_dat,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [clog2(DEPTH):0]       o_count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Head is masked while empty so a drained way presents zeros, as after reset.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/request_dispatcher.sv
// Splits one valid/issue_ack request stream into NUM_REQUEST per-way queues; ack one cycle after accept, max 1 req / 2 cycles.
// Stalls upstream while any targeted queue is full; REQUEST_DISPATCHER_MULTICAST_EN enables multi-way delivery.
module request_dispatcher
  import request_dispatcher_pkg::*;
#(
  parameter int NUM_REQUEST                  = DEF_NUM_REQUEST,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = DEF_REQUEST_WIDTH,
  parameter int QUEUE_DEPTH                  = DEF_QUEUE_DEPTH
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]       request_in,
  input  logic                                          request_valid_in,
  input  logic                                          request_critical_in,
  input  logic [NUM_REQUEST-1:0]                        request_dest_in,
  output logic                                          issue_ack_out,
  output logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_out,
  output logic [NUM_REQUEST-1:0]                        request_valid_flatted_out,
  output logic [NUM_REQUEST-1:0]                        request_critical_flatted_out,
  input  logic [NUM_REQUEST-1:0]                        issue_ack_flatted_in
);

  localparam int W       = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int ENTRY_W = W + 1;
  localparam int CNT_W   = clog2(QUEUE_DEPTH) + 1;

  logic                   r_ack;
  logic [NUM_REQUEST-1:0] w_target;
  logic [NUM_REQUEST-1:0] w_full;
  logic [NUM_REQUEST-1:0] w_empty;
  logic [NUM_REQUEST-1:0] w_push;
  logic [NUM_REQUEST-1:0] w_pop;
  logic                   w_space;
  logic                   w_accept;
  logic [ENTRY_W-1:0]     w_entry;
  logic [ENTRY_W-1:0]     w_head  [NUM_REQUEST];
  logic [CNT_W-1:0]       w_count [NUM_REQUEST];

`ifdef REQUEST_DISPATCHER_MULTICAST_EN
  assign w_target = request_dest_in;
`else
  // Two's-complement trick isolates the lowest set destination bit.
  assign w_target = request_dest_in & (~request_dest_in + NUM_REQUEST'(1));
`endif

  // The ack cycle never accepts: upstream still shows the request it just had acked.
  assign w_space  = ~|(w_target & w_full);
  assign w_accept = request_valid_in & ~r_ack & w_space;
  assign w_push   = w_target & {NUM_REQUEST{w_accept}};
  assign w_entry  = {request_critical_in, request_in};

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_accept;
    end
  end

  assign issue_ack_out = r_ack;

  for (genvar g = 0; g < NUM_REQUEST; g++) begin : g_way
    assign w_pop[g] = issue_ack_flatted_in[g] & (w_count[g] != '0);

    dispatch_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
    ) u_queue (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .i_push     (w_push[g]),
      .i_push_dat (w_entry),
      .i_pop      (w_pop[g]),
      .o_head_dat (w_head[g]),
      .o_full     (w_full[g]),
      .o_empty    (w_empty[g]),
      .o_count    (w_count[g])
    );

    assign request_flatted_out[g*W +: W]   = w_head[g][W-1:0];
    assign request_critical_flatted_out[g] = w_head[g][W];
    assign request_valid_flatted_out[g]    = ~w_empty[g];
  end

endmodule

// File: tb/tb_request_dispatcher.sv
// Directed bench for request_dispatcher: reset, streaming, backpressure, head-of-line, multicast/unicast, zero dest, mid-run reset.
module tb_request_dispatcher;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [63:0]   request_in;
  logic          request_valid_in;
  logic          request_critical_in;
  logic [2:0]    request_dest_in;
  logic          issue_ack_out;
  logic [191:0]  request_flatted_out;
  logic [2:0]    request_valid_flatted_out;
  logic [2:0]    request_critical_flatted_out;
  logic [2:0]    issue_ack_flatted_in;

  int n_checks = 0;
  int n_errors = 0;

  request_dispatcher #(
    .NUM_REQUEST                  (3),
    .SINGLE_REQUEST_WIDTH_IN_BITS (64),
    .QUEUE_DEPTH                  (4)
  ) dut (
    .clk_in                       (clk_in),
    .reset_in                     (reset_in),
    .request_in                   (request_in),
    .request_valid_in             (request_valid_in),
    .request_critical_in          (request_critical_in),
    .request_dest_in              (request_dest_in),
    .issue_ack_out                (issue_ack_out),
    .request_flatted_out          (request_flatted_out),
    .request_valid_flatted_out    (request_valid_flatted_out),
    .request_critical_flatted_out (request_critical_flatted_out),
    .issue_ack_flatted_in         (issue_ack_flatted_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] head(input int w);
    return request_flatted_out[w*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Holds a request until the ack is seen or the cycle budget runs out; returns in the ack cycle.
  task automatic send(input logic [63:0] p, input logic c, input logic [2:0] d,
                      input int budget, output logic ok);
    request_in          = p;
    request_critical_in = c;
    request_dest_in     = d;
    request_valid_in    = 1'b1;
    ok                  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (issue_ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    request_valid_in = 1'b0;
  endtask

  task automatic pop(input int w);
    issue_ack_flatted_in = 3'(1 << w);
    tick();
    issue_ack_flatted_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic [63:0] p;
    logic        c;

    reset_in             = 1'b0;
    request_in           = 64'h1234;
    request_valid_in     = 1'b1;
    request_critical_in  = 1'b1;
    request_dest_in      = 3'b001;
    issue_ack_flatted_in = '0;

    // Reset held with a valid request pending
    repeat (3) tick();
    check("rst_ack", 64'(issue_ack_out), 64'd0);
    check("rst_valid", 64'(request_valid_flatted_out), 64'd0);
    check("rst_data", 64'(|request_flatted_out), 64'd0);
    check("rst_crit", 64'(request_critical_flatted_out), 64'd0);
    reset_in = 1'b1;
    tick();
    check("first_ack", 64'(issue_ack_out), 64'd1);
    check("first_valid", 64'(request_valid_flatted_out), 64'b001);
    check("first_data", head(0), 64'h1234);
    check("first_crit", 64'(request_critical_flatted_out), 64'b001);
    request_valid_in = 1'b0;
    tick();
    check("first_ack_pulse", 64'(issue_ack_out), 64'd0);
    pop(0);
    check("first_drained", 64'(request_valid_flatted_out), 64'd0);

    // Single-way stream to way 1
    for (int n = 0; n < 16; n++) begin
      p = 64'hFFFF_FFFF_FFFF_FFFF - 64'(n);
      c = n[0];
      send(p, c, 3'b010, 4, ok);
      check("stream_ack", 64'(ok), 64'd1);
      check("stream_vld", 64'(request_valid_flatted_out), 64'b010);
      check("stream_dat", head(1), p);
      check("stream_crit", 64'(request_critical_flatted_out[1]), 64'(c));
      tick();
      check("stream_gap", 64'(issue_ack_out), 64'd0);
      pop(1);
    end
    check("stream_empty", 64'(request_valid_flatted_out), 64'd0);

    // Backpressure: way 0 sink stalled
    for (int n = 0; n < 4; n++) begin
      send(64'(100 + n), 1'b0, 3'b001, 4, ok);
      check("bp_ack", 64'(ok), 64'd1);
    end
    request_in       = 64'd104;
    request_dest_in  = 3'b001;
    request_valid_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bp_stall", 64'(issue_ack_out), 64'd0);
    end
    check("bp_head", head(0), 64'd100);
    issue_ack_flatted_in = 3'b001;
    tick();
    issue_ack_flatted_in = '0;
    check("bp_no_passthru", 64'(issue_ack_out), 64'd0);
    check("bp_pop_head", head(0), 64'd101);
    tick();
    check("bp_5th", 64'(issue_ack_out), 64'd1);
    request_valid_in = 1'b0;

    // Head-of-line: way 0 full blocks the in-order stream
    request_in       = 64'd105;
    request_dest_in  = 3'b001;
    request_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hol_stall", 64'(issue_ack_out), 64'd0);
      check("hol_w2_idle", 64'(request_valid_flatted_out[2]), 64'd0);
    end
    pop(0);
    tick();
    check("hol_accept", 64'(issue_ack_out), 64'd1);
    request_valid_in = 1'b0;
    send(64'hC0DE, 1'b1, 3'b100, 4, ok);
    check("hol_w2_ack", 64'(ok), 64'd1);
    check("hol_w2_vld", 64'(request_valid_flatted_out), 64'b101);
    check("hol_w2_dat", head(2), 64'hC0DE);
    check("hol_w2_crit", 64'(request_critical_flatted_out), 64'b100);
    pop(2);
    for (int n = 0; n < 4; n++) begin
      check("hol_order", head(0), 64'(102 + n));
      pop(0);
    end
    check("hol_empty", 64'(request_valid_flatted_out), 64'd0);

    // Destination 3'b111
    send(64'hA5, 1'b1, 3'b111, 4, ok);
    check("mc_ack", 64'(ok), 64'd1);
`ifdef REQUEST_DISPATCHER_MULTICAST_EN
    check("mc_vld", 64'(request_valid_flatted_out), 64'b111);
    check("mc_dat0", head(0), 64'hA5);
    check("mc_dat1", head(1), 64'hA5);
    check("mc_dat2", head(2), 64'hA5);
    check("mc_crit", 64'(request_critical_flatted_out), 64'b111);
    tick();
    check("mc_single_ack", 64'(issue_ack_out), 64'd0);
    issue_ack_flatted_in = 3'b111;
    tick();
    issue_ack_flatted_in = '0;
    check("mc_drained", 64'(request_valid_flatted_out), 64'd0);
    for (int n = 0; n < 4; n++) begin
      send(64'(200 + n), 1'b0, 3'b010, 4, ok);
      check("mc_fill", 64'(ok), 64'd1);
    end
    request_in       = 64'hA6;
    request_dest_in  = 3'b111;
    request_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mc_full_stall", 64'(issue_ack_out), 64'd0);
    end
    pop(1);
    tick();
    check("mc_after_pop", 64'(issue_ack_out), 64'd1);
    request_valid_in = 1'b0;
    check("mc_after_vld", 64'(request_valid_flatted_out), 64'b111);
    check("mc_after_dat0", head(0), 64'hA6);
    check("mc_after_dat1", head(1), 64'd201);
    for (int k = 0; k < 4; k++) begin
      issue_ack_flatted_in = 3'b111;
      tick();
    end
    issue_ack_flatted_in = '0;
    check("mc_final_empty", 64'(request_valid_flatted_out), 64'd0);
`else
    check("uc_vld", 64'(request_valid_flatted_out), 64'b001);
    check("uc_dat0", head(0), 64'hA5);
    check("uc_crit", 64'(request_critical_flatted_out), 64'b001);
    tick();
    check("uc_single_ack", 64'(issue_ack_out), 64'd0);
    pop(0);
    check("uc_drained", 64'(request_valid_flatted_out), 64'd0);
`endif

    // Zero destination is acked and discarded
    send(64'hDEAD, 1'b0, 3'b000, 4, ok);
    check("zero_ack", 64'(ok), 64'd1);
    check("zero_vld", 64'(request_valid_flatted_out), 64'd0);
    tick();
    check("zero_vld_later", 64'(request_valid_flatted_out), 64'd0);

    // Reset asserted mid-operation with an ack in flight
    for (int n = 0; n < 3; n++) begin
      send(64'(300 + n), 1'b1, 3'b100, 4, ok);
      check("mid_fill", 64'(ok), 64'd1);
    end
    check("mid_vld", 64'(request_valid_flatted_out), 64'b100);
    check("mid_ack_high", 64'(issue_ack_out), 64'd1);
    reset_in = 1'b0;
    #1;
    check("mid_rst_vld", 64'(request_valid_flatted_out), 64'd0);
    check("mid_rst_ack", 64'(issue_ack_out), 64'd0);
    check("mid_rst_data", 64'(|request_flatted_out), 64'd0);
    tick();
    reset_in = 1'b1;
    tick();
    check("post_rst_vld", 64'(request_valid_flatted_out), 64'd0);
    check("post_rst_ack", 64'(issue_ack_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
